// File: rtl/ras_stack_ctrl.sv
// Return-address stack controller: the top of stack lives in flops, older entries in an
// external single-cycle BRAM used as a circular buffer that overwrites the oldest entry when full.
module ras_stack_ctrl #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 36,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             ready,
  output logic             top_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [ADDR+1:0]  occupancy,
  output logic             overflow,
  output logic             underflow,
  output logic             m_we,
  output logic [ADDR-1:0]  m_waddr,
  output logic [WIDTH-1:0] m_wdata,
  output logic             m_re,
  output logic [ADDR-1:0]  m_raddr,
  input  logic [WIDTH-1:0] m_rdata
);

  typedef enum logic {IDLE, REFILL} state_t;

  localparam logic [ADDR:0] MEM_FULL = (ADDR+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [ADDR-1:0]  sp_q, sp_d;
  logic [ADDR:0]    mem_cnt_q, mem_cnt_d;
  logic             tos_valid_q, tos_valid_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    mem_cnt_d   = mem_cnt_q;
    tos_valid_d = tos_valid_q;
    tos_d       = tos_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    m_we        = 1'b0;
    m_re        = 1'b0;
    m_waddr     = sp_q;
    m_wdata     = tos_q;
    m_raddr     = sp_q - ADDR'(1);

    if (flush) begin
      state_d     = IDLE;
      sp_d        = '0;
      mem_cnt_d   = '0;
      tos_valid_d = 1'b0;
    end else if (state_q == REFILL) begin
      // The read issued by the pop lands this cycle and becomes the new top.
      tos_d   = m_rdata;
      state_d = IDLE;
    end else if (push && pop) begin
      tos_d = push_data;
      if (!tos_valid_q) begin
        tos_valid_d = 1'b1;
        underflow_d = 1'b1;
      end
    end else if (push) begin
      tos_d       = push_data;
      tos_valid_d = 1'b1;
      if (tos_valid_q) begin
        // Spill the old top; when the buffer is full the wrap overwrites the oldest entry.
        m_we = 1'b1;
        sp_d = sp_q + ADDR'(1);
        if (mem_cnt_q == MEM_FULL) overflow_d = 1'b1;
        else                       mem_cnt_d  = mem_cnt_q + (ADDR+1)'(1);
      end
    end else if (pop) begin
      if (mem_cnt_q != '0) begin
        m_re      = 1'b1;
        sp_d      = sp_q - ADDR'(1);
        mem_cnt_d = mem_cnt_q - (ADDR+1)'(1);
        state_d   = REFILL;
      end else if (tos_valid_q) begin
        tos_valid_d = 1'b0;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      mem_cnt_q   <= '0;
      tos_valid_q <= 1'b0;
      tos_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      mem_cnt_q   <= mem_cnt_d;
      tos_valid_q <= tos_valid_d;
      tos_q       <= tos_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign top_valid = tos_valid_q && (state_q == IDLE);
  assign top_data  = tos_q;
  assign occupancy = {1'b0, mem_cnt_q} + {{(ADDR+1){1'b0}}, tos_valid_q};
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ras_stack_ctrl.sv
// Self-checking bench for ras_stack_ctrl: directed vector table, hand-written corner
// sequences and random traffic, all compared against a queue-based stack model.
module tb_ras_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 36;
  localparam int ADDR  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, flush;
  logic [WIDTH-1:0] push_data;
  logic             ready, top_valid, overflow, underflow;
  logic [WIDTH-1:0] top_data;
  logic [ADDR+1:0]  occupancy;
  logic             m_we, m_re;
  logic [ADDR-1:0]  m_waddr, m_raddr;
  logic [WIDTH-1:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ras_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop), .flush(flush),
    .ready(ready), .top_valid(top_valid), .top_data(top_data), .occupancy(occupancy),
    .overflow(overflow), .underflow(underflow),
    .m_we(m_we), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_re(m_re), .m_raddr(m_raddr), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // BRAM with a one-cycle registered read
  logic [WIDTH-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (m_we) bram[m_waddr] <= m_wdata;
    if (m_re) m_rdata <= bram[m_raddr];
  end

  // Reference model: a queue holding every valid entry, oldest first, top at the back
  logic [WIDTH-1:0] stk[$];
  int  sp_m;
  bit  refill_m, ovf_m, unf_m;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    stk.delete();
    sp_m = 0; refill_m = 0; ovf_m = 0; unf_m = 0;
  endfunction

  function automatic void model_update(bit p, bit po, bit f, logic [WIDTH-1:0] d);
    int sz = stk.size();
    ovf_m = 0; unf_m = 0;
    if (f) begin
      stk.delete(); sp_m = 0; refill_m = 0;
    end else if (refill_m) begin
      refill_m = 0;
    end else if (p && po) begin
      if (sz > 0) stk[sz-1] = d;
      else begin stk.push_back(d); unf_m = 1; end
    end else if (p) begin
      if (sz > 0) begin
        sp_m = (sp_m + 1) % DEPTH;
        if (sz == DEPTH + 1) begin void'(stk.pop_front()); ovf_m = 1; end
      end
      stk.push_back(d);
    end else if (po) begin
      if (sz > 1) begin
        void'(stk.pop_back()); sp_m = (sp_m + DEPTH - 1) % DEPTH; refill_m = 1;
      end else if (sz == 1) void'(stk.pop_back());
      else unf_m = 1;
    end
  endfunction

  task automatic check_output();
    int  sz = stk.size();
    bit  exp_we = !refill_m && !flush && push && !pop && sz > 0;
    bit  exp_re = !refill_m && !flush && pop && !push && sz > 1;
    check("ready", 64'(ready), 64'(!refill_m));
    check("top_valid", 64'(top_valid), 64'(sz > 0 && !refill_m));
    if (sz > 0 && !refill_m) check("top_data", 64'(top_data), 64'(stk[sz-1]));
    check("occupancy", 64'(occupancy), 64'(sz));
    check("overflow", 64'(overflow), 64'(ovf_m));
    check("underflow", 64'(underflow), 64'(unf_m));
    check("m_we", 64'(m_we), 64'(exp_we));
    check("m_re", 64'(m_re), 64'(exp_re));
    if (exp_we) begin
      check("m_waddr", 64'(m_waddr), 64'(sp_m));
      check("m_wdata", 64'(m_wdata), 64'(stk[sz-1]));
    end
    if (exp_re) check("m_raddr", 64'(m_raddr), 64'((sp_m + DEPTH - 1) % DEPTH));
  endtask

  task automatic apply_stimulus(bit p, bit po, bit f, logic [WIDTH-1:0] d);
    @(negedge clk);
    push = p; pop = po; flush = f; push_data = d;
    #1 check_output();
    @(posedge clk);
    model_update(p, po, f, d);
  endtask

  typedef struct {
    bit p, po, f;
    logic [WIDTH-1:0] d;
    bit rdy, tv, chk_top;
    logic [WIDTH-1:0] top;
    int occ;
    bit ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit p, bit po, bit f, logic [WIDTH-1:0] d, bit rdy, bit tv,
                              bit chk_top, logic [WIDTH-1:0] top, int occ, bit ovf, bit unf);
    vec_t v;
    v.p = p; v.po = po; v.f = f; v.d = d; v.rdy = rdy; v.tv = tv; v.chk_top = chk_top;
    v.top = top; v.occ = occ; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rd;
    rst = 1'b1; push = 0; pop = 0; flush = 0; push_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_top_valid", 64'(top_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_top_data", 64'(top_data), 64'(0));
    check("rst_m_we", 64'(m_we), 64'(0));
    check("rst_m_re", 64'(m_re), 64'(0));
    @(negedge clk) rst = 1'b0;

    // push/pop/replace/flush, then fill past capacity and drain into underflow
    add(1,0,0,36'hA, 1,1,1,36'hA, 1,0,0);
    add(1,0,0,36'hB, 1,1,1,36'hB, 2,0,0);
    add(1,0,0,36'hC, 1,1,1,36'hC, 3,0,0);
    add(0,1,0,36'h0, 0,0,0,36'h0, 2,0,0);
    add(0,0,0,36'h0, 1,1,1,36'hB, 2,0,0);
    add(1,1,0,36'h7, 1,1,1,36'h7, 2,0,0);
    add(0,0,1,36'h0, 1,0,0,36'h0, 0,0,0);
    for (int i = 1; i <= 6; i++)
      add(1,0,0,36'(i), 1,1,1,36'(i), (i < 5) ? i : 5, i == 6, 0);
    for (int i = 5; i >= 2; i--) begin
      add(0,1,0,36'h0, 0,0,0,36'h0, i-1,0,0);
      add(0,0,0,36'h0, 1,1,1,36'(i), i-1,0,0);
    end
    add(0,1,0,36'h0, 1,0,0,36'h0, 0,0,0);
    add(0,1,0,36'h0, 1,0,0,36'h0, 0,0,1);

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].p, tbl[i].po, tbl[i].f, tbl[i].d);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(ready), 64'(tbl[i].rdy));
      check($sformatf("vec%0d_top_valid", i), 64'(top_valid), 64'(tbl[i].tv));
      check($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].occ));
      check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(tbl[i].unf));
      if (tbl[i].chk_top) check($sformatf("vec%0d_top_data", i), 64'(top_data), 64'(tbl[i].top));
    end

    // flush while a refill is outstanding
    apply_stimulus(1,0,0,36'h11);
    apply_stimulus(1,0,0,36'h22);
    apply_stimulus(0,1,0,36'h0);
    apply_stimulus(0,0,1,36'h0);
    #1;
    check("flush_refill_occupancy", 64'(occupancy), 64'(0));
    check("flush_refill_top_valid", 64'(top_valid), 64'(0));
    check("flush_refill_ready", 64'(ready), 64'(1));
    apply_stimulus(0,0,0,36'h0);
    apply_stimulus(0,0,0,36'h0);

    // asynchronous reset in the middle of a refill
    apply_stimulus(1,0,0,36'h33);
    apply_stimulus(1,0,0,36'h44);
    apply_stimulus(0,1,0,36'h0);
    #2 push = 0; pop = 0; rst = 1'b1;
    #1;
    check("arst_ready", 64'(ready), 64'(1));
    check("arst_top_valid", 64'(top_valid), 64'(0));
    check("arst_occupancy", 64'(occupancy), 64'(0));
    check("arst_top_data", 64'(top_data), 64'(0));
    check("arst_overflow", 64'(overflow), 64'(0));
    check("arst_underflow", 64'(underflow), 64'(0));
    check("arst_m_we", 64'(m_we), 64'(0));
    check("arst_m_re", 64'(m_re), 64'(0));
    model_reset();
    @(negedge clk) rst = 1'b0;
    apply_stimulus(0,0,0,36'h0);
    apply_stimulus(0,0,0,36'h0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      int r = int'($urandom_range(0, 99));
      rd = {4'($urandom()), $urandom()};
      apply_stimulus(r < 45 || (r >= 85 && r < 97), r >= 45 && r < 97, r >= 97, rd);
    end
    apply_stimulus(0,0,0,36'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
